// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample rate and
// mid-bit sample point used by the TX and RX ends of the link.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_e;

    localparam int unsigned OS_RATE  = 16;
    localparam int unsigned MID_TICK = 7;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Valid/ready byte stream carrying received words from the UART receiver
// to the consuming logic.
interface uart_rx_stream_if #(
    parameter int unsigned DBIT = 8
);
    logic [DBIT-1:0] data;
    logic            valid;
    logic            ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is 0 while empty.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever count is 0.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/uart_rx_stream.sv
// 16x-oversampled UART receiver with stop-bit framing check, feeding a
// small FWFT FIFO that presents bytes on a valid/ready stream.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_rx,
    uart_rx_stream_if.master rx_stream,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic             o_rx_busy
);
    localparam int unsigned SW = $clog2(max_u(SB_TICK, OS_RATE));
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    uart_rx_state_e  state_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] shreg_q;
    logic            sync1_q;
    logic            rx_s_q;
    logic            rx_prev_q;
    logic            frame_err_q;
    logic            overrun_q;

    logic            push;
    logic            pop;
    logic            overrun_d;
    logic            fifo_full;
    logic            fifo_empty;

    // The push is decoded in the stop-sample cycle itself so the word lands
    // in the FIFO on that edge and is visible one cycle later.
    assign push      = (state_q == STOP) && i_tick && (s_q == SW'(SB_TICK - 1)) && rx_s_q;
    assign pop       = rx_stream.valid && rx_stream.ready;
    assign overrun_d = push && fifo_full && !pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= i_rx;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            frame_err_q <= 1'b0;
            overrun_q   <= overrun_d;
            case (state_q)
                IDLE: begin
                    // Edge-triggered start: a line held low after a break stays idle.
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= START;
                        s_q     <= '0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (s_q == SW'(MID_TICK)) begin
                            if (!rx_s_q) begin
                                state_q <= DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (s_q == SW'(OS_RATE - 1)) begin
                            shreg_q <= {rx_s_q, shreg_q[DBIT-1:1]};
                            s_q     <= '0;
                            if (n_q == NW'(DBIT - 1)) state_q <= STOP;
                            else                      n_q     <= n_q + NW'(1);
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (s_q == SW'(SB_TICK - 1)) begin
                            frame_err_q <= !rx_s_q;
                            state_q     <= IDLE;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_fifo #(
        .WIDTH (DBIT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (shreg_q),
        .i_pop   (pop),
        .o_data  (rx_stream.data),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    assign rx_stream.valid = !fifo_empty;
    assign o_frame_err     = frame_err_q;
    assign o_overrun       = overrun_q;
    assign o_rx_busy       = (state_q != IDLE);

endmodule
